// File: rtl/fifo_umbral_pkg.sv
// Shared FIFO definitions: default geometry, per-FIFO default thresholds and
// the overflow/underflow classification used by every fifo_umbral instance.
package fifo_umbral_pkg;

    localparam int FIFO_DATA_W = 6;
    localparam int FIFO_ADDR_W = 2;

    // The three FIFO flavours that feed the switch control FSM.
    typedef enum logic [1:0] {
        FIFO_MAIN = 2'd0,
        FIFO_VC   = 2'd1,
        FIFO_D    = 2'd2
    } fifo_kind_e;

    // Occupancy thresholds as presented on af_thresh/ae_thresh.
    typedef struct packed {
        logic [FIFO_ADDR_W:0] af;
        logic [FIFO_ADDR_W:0] ae;
    } fifo_thresh_t;

    // Power-up thresholds the FSM loads before its first af*/ae* update.
    function automatic fifo_thresh_t default_thresh(input fifo_kind_e kind);
        fifo_thresh_t t;
        t.af = 3'd3;
        t.ae = 3'd1;
        case (kind)
            FIFO_D:  t.af = 3'd2;
            default: t.af = 3'd3;
        endcase
        return t;
    endfunction

    // Overflow: push into a full FIFO with no pop to make room.
    // Underflow: pop from an empty FIFO (regardless of push).
    function automatic logic err_event(input logic push, input logic pop,
                                       input logic full, input logic empty);
        return (push && full && !pop) || (pop && empty);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// 1-write/1-read register file, DEPTH x DATA_W. Synchronous write,
// combinational read; the owner registers the read data.
module fifo_mem #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store one word per accepted push.
    // NOTE: the array has no reset; contents are don't-care after reset since
    // the pointers and count decide what is readable, and a reset would cost
    // a mux on every storage bit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds.
// Owns pointers, occupancy count, flags, registered read data and error.
// Build option FIFO_ERR_STICKY_EN: when defined, error latches until reset;
// otherwise error is a one-cycle pulse per overflow/underflow event.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              error_q, error_d;

    logic              push_acc;
    logic              pop_acc;
    logic              err_evt;
    logic [DATA_W-1:0] rd_data;

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Status flags straight from the registered count and the live thresholds.
    always_comb begin
        full         = (count_q == DEPTH);
        empty        = (count_q == '0);
        almost_full  = (count_q >= af_thresh);
        almost_empty = (count_q <= ae_thresh);
    end

    // Request qualification and next-state for pointers, count, read data and error.
    always_comb begin
        // NOTE: every output of this block is given a value before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        push_acc    = push && (!full || pop);
        pop_acc     = pop && !empty;
        err_evt     = err_event(push, pop, full, empty);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = pop_acc;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = rd_data;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

`ifdef FIFO_ERR_STICKY_EN
        error_d = error_q | err_evt;
`else
        error_d = err_evt;
`endif
    end

    // State register with synchronous reset; reset empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral (DATA_W=6, ADDR_W=2, af=3, ae=1).
// Read data is checked by a monitor against a scoreboard queue filled
// when pops are issued; flags and error are checked after each cycle.
module tb_fifo_umbral;

    localparam int DW = 6;
    localparam int AW = 2;

`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb[$];
    bit            err_seen = 1'b0;

    fifo_umbral #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input bit e, input bit ae, input bit af, input bit f);
        check("empty", {31'd0, empty}, {31'd0, e});
        check("almost_empty", {31'd0, almost_empty}, {31'd0, ae});
        check("almost_full", {31'd0, almost_full}, {31'd0, af});
        check("full", {31'd0, full}, {31'd0, f});
    endtask

    // One clock of stimulus. rd_ok/rd_exp: whether this pop must return data
    // and what; evt: whether this cycle is an overflow/underflow.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit r,
                        input bit rd_ok, input logic [DW-1:0] rd_exp, input bit evt);
        push    = p;
        data_in = d;
        pop     = r;
        if (rd_ok) sb.push_back(rd_exp);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        err_seen = err_seen | evt;
        check("valid_out", {31'd0, valid_out}, {31'd0, rd_ok});
        check("error", {31'd0, error}, {31'd0, (STICKY ? err_seen : evt)});
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset    = 1'b0;
        err_seen = 1'b0;
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data_out", {26'd0, data_out}, 32'd0);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        af_thresh = 3'd3;
        ae_thresh = 3'd1;

        // Read-data monitor: every valid_out must match the oldest queued pop.
        fork
            forever begin
                @(posedge clk);
                #1;
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        check("valid_unexpected", {31'd0, valid_out}, 32'd0);
                    end else begin
                        check("rd_data", {26'd0, data_out}, {26'd0, sb.pop_front()});
                    end
                end
            end
        join_none

        // 1. Reset, then idle.
        do_reset(2);
        step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);

        // af_thresh = 0 means almost_full even when empty.
        af_thresh = 3'd0;
        #1;
        check("af_zero", {31'd0, almost_full}, 32'd1);
        af_thresh = 3'd3;
        #1;

        // 2. Fill.
        step(1'b1, 6'h01, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'h02, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'h03, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 6'h04, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b1);

        // 3. Overflow: dropped write, error next cycle.
        step(1'b1, 6'h3F, 1'b0, 1'b0, 6'h00, 1'b1);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b1);

        // 4. Push+pop while full, then drain across the pointer wrap.
        step(1'b1, 6'h05, 1'b1, 1'b1, 6'h01, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 6'h00, 1'b1, 1'b1, 6'h02, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b1, 6'h03, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b1, 6'h04, 1'b0);
        chk_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b1, 6'h05, 1'b0);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        check("data_out_hold", {26'd0, data_out}, 32'h05);

        // 5. Underflow, back-to-back, then recovery.
        step(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
        step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);

        // Push+pop while empty: push lands, pop underflows, no fall-through.
        step(1'b1, 6'h2A, 1'b1, 1'b0, 6'h00, 1'b1);
        chk_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b1, 6'h2A, 1'b0);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);

        // Live thresholds with two entries.
        step(1'b1, 6'h11, 1'b0, 1'b0, 6'h00, 1'b0);
        step(1'b1, 6'h22, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        ae_thresh = 3'd2;
        af_thresh = 3'd2;
        #1;
        chk_flags(1'b0, 1'b1, 1'b1, 1'b0);
        ae_thresh = 3'd1;
        af_thresh = 3'd3;
        #1;
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);

        // 6. Reset with two entries discards them; next pop underflows.
        do_reset(1);
        step(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
        chk_flags(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
